config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_sequencer.sv | 162 ++++++++++++++++
 tb/tb_config_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_sequencer.sv
// Configuration shift-chain sequencer: turns a write-data word stream into
// CONFIGIN/CONFIGOUT command pairs and packs the returned readback bits into words.
module config_sequencer #(
    parameter int MAX_BITS = 5164,
    parameter int CNT_W    = 13
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             start,
    input  logic [CNT_W-1:0] nbits,
    input  logic             do_reset,
    input  logic             superpix_sel,
    input  logic             abort,
    input  logic             wd_valid,
    input  logic [31:0]      wd_data,
    output logic             wd_ready,
    output logic             cmd_valid,
    output logic [31:0]      cmd_data,
    input  logic             cmd_ready,
    input  logic             rb_valid,
    input  logic             rb_bit,
    output logic             ro_valid,
    output logic [31:0]      ro_data,
    input  logic             ro_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] bits_done
);

    typedef enum logic [2:0] {
        IDLE, RST_CMD, FETCH, SHIFT_CMD, READ_CMD, READ_WAIT, EMIT, FINISH
    } state_t;

    localparam logic [3:0]       OP_RESET  = 4'b0001;
    localparam logic [3:0]       OP_CFGIN  = 4'b0010;
    localparam logic [3:0]       OP_CFGOUT = 4'b0100;
    localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_BITS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] nbits_q, bits_nxt;
    logic [31:0]      shbuf_q, ro_word_q;
    logic             superpix_q, seq_q, err_q, ovf_q;
    logic             rb_take, abort_now;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        wd_ready  = 1'b0;
        ro_valid  = 1'b0;
        rb_take   = 1'b0;
        abort_now = 1'b0;
        bits_nxt  = bits_done + CNT_W'(1);
        unique case (state)
            IDLE: begin
                if (start && nbits <= MAX_N) state_nxt = do_reset ? RST_CMD : FETCH;
            end
            RST_CMD: begin
                cmd_valid     = 1'b1;
                cmd_data[3:0] = OP_RESET;
                cmd_data[5]   = superpix_q;
                if (cmd_ready) begin
                    if (abort)                 abort_now = 1'b1;
                    else if (nbits_q == '0)    state_nxt = FINISH;
                    else                       state_nxt = FETCH;
                end
            end
            FETCH: begin
                // A new word is pulled only at each 32-bit boundary of the chain.
                if (bits_done != nbits_q && bits_done[4:0] == 5'd0) wd_ready = 1'b1;
                if (abort)                       abort_now = 1'b1;
                else if (bits_done == nbits_q)   state_nxt = FINISH;
                else if (!wd_ready || wd_valid)  state_nxt = SHIFT_CMD;
            end
            SHIFT_CMD: begin
                cmd_valid     = 1'b1;
                cmd_data[3:0] = OP_CFGIN;
                cmd_data[6]   = shbuf_q[0];
                if (cmd_ready) begin
                    if (abort) abort_now = 1'b1;
                    else       state_nxt = READ_CMD;
                end
            end
            READ_CMD: begin
                cmd_valid     = 1'b1;
                cmd_data[3:0] = OP_CFGOUT;
                if (cmd_ready) begin
                    if (abort) abort_now = 1'b1;
                    else       state_nxt = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (abort) abort_now = 1'b1;
                else if (rb_valid) begin
                    rb_take   = 1'b1;
                    state_nxt = (bits_nxt[4:0] == 5'd0 || bits_nxt == nbits_q) ? EMIT : FETCH;
                end
            end
            EMIT: begin
                ro_valid = 1'b1;
                if (abort)         abort_now = 1'b1;
                else if (ro_ready) state_nxt = (bits_done == nbits_q) ? FINISH : FETCH;
            end
            FINISH: state_nxt = IDLE;
        endcase
        if (cmd_valid) cmd_data[31] = seq_q;
        if (abort_now) state_nxt = FINISH;
    end

    assign ro_data = ro_word_q;
    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH) || ovf_q;
    assign err     = ((state == FINISH) && err_q) || ovf_q;

    // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            nbits_q    <= '0;
            superpix_q <= 1'b0;
            seq_q      <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            shbuf_q    <= '0;
            ro_word_q  <= '0;
            bits_done  <= '0;
        end else begin
            ovf_q <= 1'b0;
            // The engine drops repeated identical words, so every accepted command flips bit 31.
            if (cmd_valid && cmd_ready) seq_q <= ~seq_q;
            if (state == IDLE && start) begin
                bits_done <= '0;
                ro_word_q <= '0;
                err_q     <= 1'b0;
                if (nbits > MAX_N) begin
                    ovf_q <= 1'b1;
                end else begin
                    nbits_q    <= nbits;
                    superpix_q <= superpix_sel;
                end
            end
            if (state == FETCH && wd_ready && wd_valid) shbuf_q <= wd_data;
            if (state == SHIFT_CMD && cmd_ready)        shbuf_q <= shbuf_q >> 1;
            if (rb_take) begin
                ro_word_q[bits_done[4:0]] <= rb_bit;
                bits_done                 <= bits_nxt;
            end
            if (state == EMIT && ro_ready) ro_word_q <= '0;
            if (abort_now) begin
                err_q     <= 1'b1;
                ro_word_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: a table of sequences run against a small
// engine/readback responder, plus a mid-sequence reset case.
module tb_config_sequencer;

    localparam int MAX_BITS = 5164;
    localparam int CNT_W    = 13;
    localparam int BUDGET   = 3000;
    localparam int NVEC     = 9;

    logic             S_AXI_ACLK = 1'b0;
    logic             S_AXI_ARESETN = 1'b0;
    logic             start = 1'b0, do_reset = 1'b0, superpix_sel = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] nbits = '0;
    logic             wd_valid = 1'b0, wd_ready;
    logic [31:0]      wd_data = '0;
    logic             cmd_valid, cmd_ready = 1'b0;
    logic [31:0]      cmd_data;
    logic             rb_valid = 1'b0, rb_bit = 1'b0;
    logic             ro_valid, ro_ready = 1'b0;
    logic [31:0]      ro_data;
    logic             busy, done, err;
    logic [CNT_W-1:0] bits_done;

    config_sequencer #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .start        (start),
        .nbits        (nbits),
        .do_reset     (do_reset),
        .superpix_sel (superpix_sel),
        .abort        (abort),
        .wd_valid     (wd_valid),
        .wd_data      (wd_data),
        .wd_ready     (wd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .rb_valid     (rb_valid),
        .rb_bit       (rb_bit),
        .ro_valid     (ro_valid),
        .ro_data      (ro_data),
        .ro_ready     (ro_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bits_done    (bits_done)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    typedef struct {
        logic             do_rst;
        logic             sp;
        logic [CNT_W-1:0] nb;
        logic [31:0]      w0, w1, p0, p1;
        logic             stall, noise;
        int               abort_at, restart_at;
        int               exp_cmds, exp_wd, exp_ro;
        logic [31:0]      exp_ro0, exp_ro1;
        logic             exp_err;
        logic [CNT_W-1:0] exp_bits;
        int               exp_lat;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [31:0] spec040 [7];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        exp_seq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        vec_t        t;
        logic [31:0] expq[$], got[$], roq[$];
        logic [31:0] prev_cmd;
        logic        prev_pend, fin, got_err, got_busy, busy1, bitv;
        logic [CNT_W-1:0] got_bits;
        int cyc, nb_run, wd_cnt, n_out, n_rb, rb_delay, hold_bad, lat, idx, ncmp;
        logic rb_pend;
        t = vecs[v];
        prev_cmd = '0; prev_pend = 1'b0; fin = 1'b0; got_err = 1'b0; got_busy = 1'b0;
        busy1 = 1'b0; got_bits = '0; wd_cnt = 0; n_out = 0; n_rb = 0; rb_delay = 0;
        hold_bad = 0; lat = -1; rb_pend = 1'b0;

        // Expected command stream built from the stimulus and the running seq toggle.
        if (t.nb <= CNT_W'(MAX_BITS)) begin
            if (t.do_rst) begin
                expq.push_back({exp_seq, 25'd0, t.sp, 1'b0, 4'b0001});
                exp_seq = ~exp_seq;
            end
            nb_run = (t.abort_at >= 0) ? t.abort_at + 1 : int'(t.nb);
            for (int i = 0; i < nb_run; i++) begin
                bitv = (i < 32) ? t.w0[i] : t.w1[i-32];
                expq.push_back({exp_seq, 24'd0, bitv, 2'b00, 4'b0010});
                exp_seq = ~exp_seq;
                expq.push_back({exp_seq, 27'd0, 4'b0100});
                exp_seq = ~exp_seq;
            end
        end

        start = 1'b1; nbits = t.nb; do_reset = t.do_rst; superpix_sel = t.sp;
        wd_valid = 1'b1; wd_data = t.w0; cmd_ready = 1'b1; ro_ready = 1'b1;
        abort = 1'b0; rb_valid = 1'b0;
        cyc = 0;
        while (1) begin
            #1;
            if (prev_pend && (!cmd_valid || cmd_data !== prev_cmd)) hold_bad++;
            prev_pend = cmd_valid && !cmd_ready;
            prev_cmd  = cmd_data;
            if (cmd_valid && cmd_ready) begin
                got.push_back(cmd_data);
                if (cmd_data[3:0] == 4'b0100) begin
                    rb_pend  = 1'b1;
                    n_out++;
                    rb_delay = t.stall ? int'($urandom_range(0, 2)) : 0;
                end
            end
            if (wd_valid && wd_ready) wd_cnt++;
            if (ro_valid && ro_ready) roq.push_back(ro_data);
            if (cyc == 1) busy1 = busy;
            if (done) begin
                fin = 1'b1; got_err = err; got_busy = busy; got_bits = bits_done; lat = cyc;
            end
            if (fin || cyc >= BUDGET) break;
            @(posedge S_AXI_ACLK); cyc++; #1;
            start = (cyc == t.restart_at);
            if (cyc == t.restart_at) begin
                nbits = CNT_W'(5); do_reset = 1'b1; superpix_sel = 1'b1;
            end
            wd_data   = (wd_cnt == 0) ? t.w0 : t.w1;
            cmd_ready = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ro_ready  = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            abort = 1'b0; rb_valid = 1'b0; rb_bit = 1'b0;
            if (rb_pend) begin
                if (t.abort_at >= 0 && n_out == t.abort_at + 1) begin
                    abort = 1'b1; rb_pend = 1'b0;
                end else if (rb_delay == 0) begin
                    rb_valid = 1'b1;
                    rb_bit   = (n_rb < 32) ? t.p0[n_rb] : t.p1[n_rb-32];
                    n_rb++;
                    rb_pend = 1'b0;
                end else begin
                    rb_delay--;
                end
            end else if (t.noise) begin
                rb_valid = 1'b1; rb_bit = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0; rb_valid = 1'b0;

        check($sformatf("v%0d done_seen", v), 32'(fin), 32'd1);
        check($sformatf("v%0d cmd_count", v), 32'(got.size()), 32'(t.exp_cmds));
        check($sformatf("v%0d model_count", v), 32'(got.size()), 32'(expq.size()));
        ncmp = (got.size() < expq.size()) ? got.size() : expq.size();
        if (ncmp > 0) begin
            idx = ncmp - 1;
            for (int k = 0; k < ncmp; k++)
                if (got[k] !== expq[k]) begin idx = k; break; end
            check($sformatf("v%0d cmd_stream[%0d]", v, idx), got[idx], expq[idx]);
        end
        if (v == 0)
            for (int k = 0; k < 7; k++)
                check($sformatf("v0 literal_cmd[%0d]", k),
                      (k < got.size()) ? got[k] : 32'hDEAD_BEEF, spec040[k]);
        check($sformatf("v%0d cmd_hold_violations", v), 32'(hold_bad), 32'd0);
        check($sformatf("v%0d wd_transfers", v), 32'(wd_cnt), 32'(t.exp_wd));
        check($sformatf("v%0d ro_transfers", v), 32'(roq.size()), 32'(t.exp_ro));
        if (t.exp_ro >= 1 && roq.size() >= 1) check($sformatf("v%0d ro_word0", v), roq[0], t.exp_ro0);
        if (t.exp_ro >= 2 && roq.size() >= 2) check($sformatf("v%0d ro_word1", v), roq[1], t.exp_ro1);
        check($sformatf("v%0d err_with_done", v), 32'(got_err), 32'(t.exp_err));
        check($sformatf("v%0d busy_at_done", v), 32'(got_busy), 32'd0);
        check($sformatf("v%0d busy_after_start", v), 32'(busy1), 32'(t.nb <= CNT_W'(MAX_BITS)));
        check($sformatf("v%0d bits_done", v), 32'(got_bits), 32'(t.exp_bits));
        if (t.exp_lat >= 0) check($sformatf("v%0d done_latency", v), 32'(lat), 32'(t.exp_lat));

        if (!fin) begin
            S_AXI_ARESETN = 1'b0;
            @(posedge S_AXI_ACLK); #1;
            S_AXI_ARESETN = 1'b1;
            exp_seq = 1'b0;
        end else begin
            @(posedge S_AXI_ACLK); #1;
            check($sformatf("v%0d done_err_busy_after_pulse", v), 32'({done, err, busy}), 32'd0);
        end
    endtask

    initial begin
        spec040 = '{32'h0000_0021, 32'h8000_0042, 32'h0000_0004, 32'h8000_0002,
                    32'h0000_0004, 32'h8000_0042, 32'h0000_0004};
        //          rst sp  nb     w0            w1         p0            p1            stl noi abrt rst  cmd wd ro ro0           ro1           err bits  lat
        vecs[0] = '{1'b1, 1'b1, 13'd3,    32'h5,        32'h0,  32'h6,        32'h0,        1'b0, 1'b0, -1, -1,  7, 1, 1, 32'h6,        32'h0,  1'b0, 13'd3,  -1};
        vecs[1] = '{1'b0, 1'b0, 13'd40,   32'hA5A5F00F, 32'h3C, 32'hDEADBEEF, 32'h123,      1'b1, 1'b0, -1, -1, 80, 2, 2, 32'hDEADBEEF, 32'h23, 1'b0, 13'd40, -1};
        vecs[2] = '{1'b0, 1'b0, 13'd32,   32'hFFFF0000, 32'h0,  32'h80000001, 32'h0,        1'b0, 1'b1, -1, -1, 64, 1, 1, 32'h80000001, 32'h0,  1'b0, 13'd32, -1};
        vecs[3] = '{1'b1, 1'b1, 13'd33,   32'h1,        32'h1,  32'h0,        32'hFFFFFFFF, 1'b1, 1'b1, -1, -1, 67, 2, 2, 32'h0,        32'h1,  1'b0, 13'd33, -1};
        vecs[4] = '{1'b1, 1'b0, 13'd5165, 32'h0,        32'h0,  32'h0,        32'h0,        1'b0, 1'b0, -1, -1,  0, 0, 0, 32'h0,        32'h0,  1'b1, 13'd0,   1};
        vecs[5] = '{1'b1, 1'b0, 13'd0,    32'h0,        32'h0,  32'h0,        32'h0,        1'b0, 1'b0, -1, -1,  1, 0, 0, 32'h0,        32'h0,  1'b0, 13'd0,  -1};
        vecs[6] = '{1'b0, 1'b0, 13'd0,    32'h0,        32'h0,  32'h0,        32'h0,        1'b0, 1'b0, -1, -1,  0, 0, 0, 32'h0,        32'h0,  1'b0, 13'd0,   2};
        vecs[7] = '{1'b1, 1'b0, 13'd40,   32'h0F0F0F0F, 32'h0,  32'h3FF,      32'h0,        1'b0, 1'b1, 10, -1, 23, 1, 0, 32'h0,        32'h0,  1'b1, 13'd10, -1};
        vecs[8] = '{1'b0, 1'b0, 13'd3,    32'h2,        32'h0,  32'h7,        32'h0,        1'b0, 1'b0, -1,  4,  6, 1, 1, 32'h7,        32'h0,  1'b0, 13'd3,  -1};

        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        check("reset ctrl outputs", 32'({cmd_valid, wd_ready, ro_valid, busy, done, err}), 32'd0);
        check("reset cmd_data", cmd_data, 32'd0);
        check("reset ro_data", ro_data, 32'd0);
        check("reset bits_done", 32'(bits_done), 32'd0);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        exp_seq = 1'b0;
        @(posedge S_AXI_ACLK); #1;

        for (int v = 0; v < NVEC; v++) run_vec(v);

        // Reset while parked in SHIFT_CMD with the engine stalled.
        cmd_ready = 1'b0; start = 1'b1; nbits = CNT_W'(8); do_reset = 1'b0;
        wd_valid = 1'b1; wd_data = 32'hFF;
        for (int k = 0; k < 20; k++) begin
            @(posedge S_AXI_ACLK); #1;
            start = 1'b0;
            #1;
            if (cmd_valid && cmd_data[3:0] == 4'b0010) break;
        end
        check("rst_test parked in SHIFT_CMD", 32'({cmd_valid, cmd_data[3:0]}), 32'h12);
        S_AXI_ARESETN = 1'b0;
        #1;
        check("rst_test ctrl outputs", 32'({cmd_valid, wd_ready, ro_valid, busy, done, err}), 32'd0);
        check("rst_test cmd_data", cmd_data, 32'd0);
        check("rst_test bits_done", 32'(bits_done), 32'd0);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        exp_seq = 1'b0;
        cmd_ready = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        check("rst_test after release", 32'({cmd_valid, wd_ready, ro_valid, busy, done, err}), 32'd0);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
